rst_seq: RTL and testbench
==========================

# rst_seq

Reset sequencer that sits in front of the core reset outputs and owns reset ordering for the SoC. It merges the hard reset with watchdog, software and JTAG reset requests. For software resets it first drains bus traffic through a quiesce handshake. It then releases the bus, peripheral and core reset domains in a fixed staged order. It records the cause of the most recent reset for a CSR read.

## Interface
- HOLD_CYC, 16: cycles all domains stay in reset after the last reset event (≥2)
- STAGE_CYC, 4: cycles between successive domain releases (≥1)
- DRAIN_TO, 64: maximum cycles to wait for quiesce_ack (≥1)
- CW, 8: internal counter width; must hold max(HOLD_CYC, STAGE_CYC, DRAIN_TO)

- clk  in  1  system clock
- rst  in  1  hard reset, synchronous, active-high
- wdg_req  in  1  watchdog reset request (level, sampled each edge)
- soft_req  in  1  software reset request (level or pulse)
- jtag_req  in  1  JTAG/debug reset request
- quiesce_ack  in  1  bus reports no outstanding transactions
- cause_clr  in  1  one-cycle pulse, clears rst_cause
- quiesce_req  out  1  asks bus masters to stop issuing and drain
- bus_rst_n  out  1  bus/interconnect reset, active-low
- periph_rst_n  out  1  peripheral reset, active-low
- core_rst_n  out  1  core reset, active-low
- rst_cause  out  5  {drain_timeout, jtag, wdg, soft, hard}, sticky
- busy  out  1  high in any state other than RUN

## Operation
- All outputs are registered. States: ASSERT, REL_BUS, REL_PERIPH, RUN, DRAIN.
- rst=1 forces ASSERT in any state: counter=0, all *_rst_n=0, quiesce_req=0, busy=1, rst_cause=5'b00001. Reset has priority over every other input.
- ASSERT: all *_rst_n=0. The counter increments each cycle. When it reaches HOLD_CYC, set bus_rst_n=1, clear the counter and go to REL_BUS.
- REL_BUS: after STAGE_CYC cycles, set periph_rst_n=1 and go to REL_PERIPH.
- REL_PERIPH: after STAGE_CYC cycles, set core_rst_n=1 and busy=0, then go to RUN.
- RUN:
  - wdg_req or jtag_req: go to ASSERT immediately, without draining.
  - soft_req alone: go to DRAIN with quiesce_req=1.
- DRAIN: outputs unchanged from RUN, quiesce_req=1.
  - quiesce_ack=1: go to ASSERT.
  - DRAIN_TO cycles elapse without ack: go to ASSERT and set cause bit 4.
  - wdg_req or jtag_req during DRAIN: abort the drain and go to ASSERT.
  - quiesce_req drops to 0 on entry to ASSERT.
- Any wdg_req, soft_req or jtag_req in ASSERT, REL_BUS or REL_PERIPH:
  - Return to ASSERT, clear the counter and drive all *_rst_n=0 on the next edge.
  - soft_req does not trigger a drain here.
- Cause rules:
  - Leaving RUN overwrites rst_cause with the bits of all requests sampled in the triggering cycle.
  - Requests arriving while sequencing, and the drain timeout, OR into rst_cause.
  - cause_clr is honoured only in RUN. When cause_clr and a request occur in the same cycle, the request's overwrite wins.
- Counter arithmetic is unsigned CW bits and never wraps, because compares end each phase first.

## Timing
- Numbering edges from the first edge with rst=0 as edge 1:
  - bus_rst_n rises after edge HOLD_CYC.
  - periph_rst_n rises after edge HOLD_CYC+STAGE_CYC.
  - core_rst_n and busy=0 follow after edge HOLD_CYC+2·STAGE_CYC.
  - With default parameters these are edges 16, 20 and 24.
- wdg_req/jtag_req sampled in RUN at edge n: all *_rst_n=0 after edge n. The release sequence then restarts counting from edge n+1.
- soft_req sampled in RUN at edge n: quiesce_req=1 after edge n.
- quiesce_ack sampled at edge m>n: *_rst_n=0 and quiesce_req=0 after edge m.
- Timeout: ASSERT is entered after edge n+DRAIN_TO.
- A request held high keeps the block in ASSERT. Release begins HOLD_CYC edges after the request drops.
- quiesce_ack is ignored outside DRAIN.

## Test plan
- Hard reset → release order:
  - Stimulus: rst high for 3 cycles, then low; defaults.
  - Required: bus_rst_n at edge 16, periph_rst_n at 20, core_rst_n at 24, busy=0 at 24, rst_cause=5'b00001.
- Watchdog reset from RUN:
  - Stimulus: wdg_req pulse at edge n.
  - Required: all *_rst_n=0 after n, released at n+16/20/24, rst_cause=5'b00100, quiesce_req never asserted.
- Soft reset with ack:
  - Stimulus: soft_req at n, quiesce_ack at n+5.
  - Required: quiesce_req high over edges n..n+5, reset asserted after n+5, rst_cause=5'b00010.
- Soft reset timeout:
  - Stimulus: soft_req, no ack.
  - Required: ASSERT entered after 64 cycles, rst_cause=5'b10010.
- JTAG aborts drain, plus late request:
  - Stimulus: soft_req at n, jtag_req at n+3; then wdg_req during REL_PERIPH.
  - Required: ASSERT after n+3, rst_cause=5'b01010 then 5'b01110, release counting restarts, core_rst_n stays 0 until 24 edges after the wdg pulse.
- Cause clear and collision:
  - Stimulus: cause_clr in RUN, then cause_clr together with jtag_req; also rst asserted mid-REL_BUS.
  - Required: rst_cause clears to 0, then reads 5'b01000; rst mid-release forces all *_rst_n=0 and rst_cause=5'b00001 on the next edge.

Source files
------------

// File: rtl/rst_seq.sv
// rst_seq: SoC reset sequencer.
// Merges the hard reset with watchdog/software/JTAG requests, drains the bus
// before software resets, releases bus -> peripheral -> core in a fixed order,
// and keeps a sticky record of what caused the most recent reset.
module rst_seq #(
  parameter int HOLD_CYC  = 16,
  parameter int STAGE_CYC = 4,
  parameter int DRAIN_TO  = 64,
  parameter int CW        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wdg_req,
  input  logic       soft_req,
  input  logic       jtag_req,
  input  logic       quiesce_ack,
  input  logic       cause_clr,
  output logic       quiesce_req,
  output logic       bus_rst_n,
  output logic       periph_rst_n,
  output logic       core_rst_n,
  output logic [4:0] rst_cause,
  output logic       busy
);

  localparam logic [2:0] S_ASSERT     = 3'd0;
  localparam logic [2:0] S_REL_BUS    = 3'd1;
  localparam logic [2:0] S_REL_PERIPH = 3'd2;
  localparam logic [2:0] S_RUN        = 3'd3;
  localparam logic [2:0] S_DRAIN      = 3'd4;

  // Phases end when the counter holds (length-1), so the transition lands
  // exactly on the Nth edge of the phase.
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_CYC - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_TO - 1);

  logic [2:0]    state, nxt_state;
  logic [CW-1:0] cnt, nxt_cnt;
  logic          timeout_hit;
  logic          any_hard, any_req;
  logic [4:0]    req_bits;

  assign any_hard = wdg_req | jtag_req;
  assign any_req  = any_hard | soft_req;
  assign req_bits = {1'b0, jtag_req, wdg_req, soft_req, 1'b0};

  // Next-state / counter decode; any request while sequencing restarts the hold.
  always_comb begin
    nxt_state   = state;
    nxt_cnt     = cnt + 1'b1;
    timeout_hit = 1'b0;
    case (state)
      S_ASSERT: begin
        if (any_req) begin
          nxt_cnt = '0;
        end else if (cnt == HOLD_LAST) begin
          nxt_state = S_REL_BUS;
          nxt_cnt   = '0;
        end
      end
      S_REL_BUS: begin
        if (any_req) begin
          nxt_state = S_ASSERT;
          nxt_cnt   = '0;
        end else if (cnt == STAGE_LAST) begin
          nxt_state = S_REL_PERIPH;
          nxt_cnt   = '0;
        end
      end
      S_REL_PERIPH: begin
        if (any_req) begin
          nxt_state = S_ASSERT;
          nxt_cnt   = '0;
        end else if (cnt == STAGE_LAST) begin
          nxt_state = S_RUN;
          nxt_cnt   = '0;
        end
      end
      S_RUN: begin
        nxt_cnt = '0;
        if (any_hard)      nxt_state = S_ASSERT;
        else if (soft_req) nxt_state = S_DRAIN;
      end
      S_DRAIN: begin
        if (any_hard || quiesce_ack) begin
          nxt_state = S_ASSERT;
          nxt_cnt   = '0;
        end else if (cnt == DRAIN_LAST) begin
          nxt_state   = S_ASSERT;
          nxt_cnt     = '0;
          timeout_hit = 1'b1;
        end
      end
      default: begin
        nxt_state = S_ASSERT;
        nxt_cnt   = '0;
      end
    endcase
  end

  // State, counter and registered outputs; outputs decode the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_ASSERT;
      cnt          <= '0;
      bus_rst_n    <= 1'b0;
      periph_rst_n <= 1'b0;
      core_rst_n   <= 1'b0;
      quiesce_req  <= 1'b0;
      busy         <= 1'b1;
    end else begin
      state        <= nxt_state;
      cnt          <= nxt_cnt;
      bus_rst_n    <= (nxt_state != S_ASSERT);
      periph_rst_n <= (nxt_state == S_REL_PERIPH) || (nxt_state == S_RUN) ||
                      (nxt_state == S_DRAIN);
      core_rst_n   <= (nxt_state == S_RUN) || (nxt_state == S_DRAIN);
      quiesce_req  <= (nxt_state == S_DRAIN);
      busy         <= (nxt_state != S_RUN);
    end
  end

  // Cause tracking: leaving RUN overwrites, anything during sequencing ORs in.
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_cause <= 5'b00001;
    end else if (state == S_RUN) begin
      if (any_req)        rst_cause <= req_bits;
      else if (cause_clr) rst_cause <= 5'b00000;
    end else begin
      rst_cause <= rst_cause | req_bits | {timeout_hit, 4'b0000};
    end
  end

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: directed plan steps followed by a randomized phase, all checked
// each cycle against an edge-counting reference model.
module tb_rst_seq;

  localparam int H = 16;
  localparam int S = 4;
  localparam int D = 64;

  logic       clk = 1'b0;
  logic       rst, wdg_req, soft_req, jtag_req, quiesce_ack, cause_clr;
  logic       quiesce_req, bus_rst_n, periph_rst_n, core_rst_n, busy;
  logic [4:0] rst_cause;

  int checks = 0;
  int errors = 0;

  // Reference model: edges since the last reset event, plus drain bookkeeping.
  int         m_age   = 0;
  bit         m_drain = 1'b0;
  int         m_dage  = 0;
  logic [4:0] m_cause = 5'b00001;

  rst_seq #(.HOLD_CYC(H), .STAGE_CYC(S), .DRAIN_TO(D), .CW(8)) dut (
    .clk(clk), .rst(rst), .wdg_req(wdg_req), .soft_req(soft_req),
    .jtag_req(jtag_req), .quiesce_ack(quiesce_ack), .cause_clr(cause_clr),
    .quiesce_req(quiesce_req), .bus_rst_n(bus_rst_n),
    .periph_rst_n(periph_rst_n), .core_rst_n(core_rst_n),
    .rst_cause(rst_cause), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input bit r, w, s, j, a, c);
    logic [4:0] rb;
    bit running;
    rb = {1'b0, j, w, s, 1'b0};
    running = (m_age >= H + 2*S) && !m_drain;
    if (r) begin
      m_age = 0; m_drain = 1'b0; m_cause = 5'b00001;
    end else if (m_drain) begin
      m_cause |= rb;
      m_dage++;
      if (w || j || a) begin
        m_drain = 1'b0; m_age = 0;
      end else if (m_dage == D) begin
        m_cause |= 5'b10000; m_drain = 1'b0; m_age = 0;
      end
    end else if (running) begin
      if (w || j) begin
        m_age = 0; m_cause = rb;
      end else if (s) begin
        m_drain = 1'b1; m_dage = 0; m_cause = rb;
      end else if (c) begin
        m_cause = 5'b00000;
      end
    end else begin
      m_cause |= rb;
      if (w || s || j) m_age = 0;
      else if (m_age < H + 2*S) m_age++;
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, check mid-cycle.
  task automatic step(input bit r, w, s, j, a, c);
    rst = r; wdg_req = w; soft_req = s; jtag_req = j; quiesce_ack = a; cause_clr = c;
    @(posedge clk);
    model(r, w, s, j, a, c);
    @(negedge clk);
    chk("bus_rst_n",    {4'b0, bus_rst_n},    {4'b0, 1'(m_age >= H)});
    chk("periph_rst_n", {4'b0, periph_rst_n}, {4'b0, 1'(m_age >= H + S)});
    chk("core_rst_n",   {4'b0, core_rst_n},   {4'b0, 1'(m_age >= H + 2*S)});
    chk("busy",         {4'b0, busy},         {4'b0, 1'(m_drain || m_age < H + 2*S)});
    chk("quiesce_req",  {4'b0, quiesce_req},  {4'b0, m_drain});
    chk("rst_cause",    rst_cause,            m_cause);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; wdg_req = 0; soft_req = 0; jtag_req = 0; quiesce_ack = 0; cause_clr = 0;
    @(negedge clk);

    // Hard reset and default release order (edges 16/20/24).
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
    idle(15);
    chk("hard_bus_edge15", {4'b0, bus_rst_n}, 5'd0);
    idle(1);
    chk("hard_bus_edge16", {4'b0, bus_rst_n}, 5'd1);
    idle(8);
    chk("hard_core_edge24", {3'b0, core_rst_n, busy}, 5'b00010);
    chk("hard_cause", rst_cause, 5'b00001);

    // Watchdog from RUN: no drain.
    step(0, 1, 0, 0, 0, 0);
    chk("wdg_assert", {2'b0, bus_rst_n, periph_rst_n, core_rst_n}, 5'd0);
    idle(24);
    chk("wdg_cause", rst_cause, 5'b00100);
    chk("wdg_released", {4'b0, core_rst_n}, 5'd1);

    // Soft reset acknowledged 5 edges later.
    step(0, 0, 1, 0, 0, 0);
    idle(4);
    chk("soft_qreq_held", {4'b0, quiesce_req}, 5'd1);
    step(0, 0, 0, 0, 1, 0);
    chk("soft_ack_assert", {1'b0, quiesce_req, bus_rst_n, periph_rst_n, core_rst_n}, 5'd0);
    idle(24);
    chk("soft_cause", rst_cause, 5'b00010);

    // Soft reset with no ack times out after DRAIN_TO edges.
    step(0, 0, 1, 0, 0, 0);
    idle(D - 1);
    chk("to_still_drain", {4'b0, quiesce_req}, 5'd1);
    idle(1);
    chk("to_assert", {1'b0, quiesce_req, bus_rst_n, periph_rst_n, core_rst_n}, 5'd0);
    chk("to_cause", rst_cause, 5'b10010);
    idle(24);

    // JTAG aborts drain, then a watchdog pulse during REL_PERIPH.
    step(0, 0, 1, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 1, 0, 0);
    chk("jtag_cause", rst_cause, 5'b01010);
    idle(21);
    chk("late_in_periph", {3'b0, periph_rst_n, core_rst_n}, 5'b00010);
    step(0, 1, 0, 0, 0, 0);
    chk("late_cause", rst_cause, 5'b01110);
    idle(23);
    chk("late_core_held", {4'b0, core_rst_n}, 5'd0);
    idle(1);
    chk("late_core_rel", {4'b0, core_rst_n}, 5'd1);

    // Cause clear, clear colliding with JTAG, then rst in the middle of REL_BUS.
    step(0, 0, 0, 0, 0, 1);
    chk("clr_cause", rst_cause, 5'b00000);
    step(0, 0, 0, 1, 0, 1);
    chk("clr_collide", rst_cause, 5'b01000);
    idle(17);
    chk("mid_relbus", {4'b0, bus_rst_n}, 5'd1);
    step(1, 0, 0, 0, 0, 0);
    chk("mid_rst", {2'b0, bus_rst_n, periph_rst_n, core_rst_n}, 5'd0);
    chk("mid_rst_cause", rst_cause, 5'b00001);
    idle(24);

    // Randomized phase; ack is withheld in alternate windows to reach timeouts.
    for (int i = 0; i < 2400; i++) begin
      bit r, w, s, j, a, c;
      r = ($urandom_range(0, 299) == 0);
      w = ($urandom_range(0, 79) == 0);
      j = ($urandom_range(0, 79) == 0);
      s = ($urandom_range(0, 29) == 0);
      a = ((i % 600) < 300) ? 1'b0 : ($urandom_range(0, 9) == 0);
      c = ($urandom_range(0, 15) == 0);
      step(r, w, s, j, a, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
